wbp2classic: RTL and testbench

- Converts a Wishbone pipelined master (upstream) into a Wishbone classic master (downstream); the counterpart of the classic-to-pipelined bridge.
- Pipelined requests are buffered in a small FIFO and replayed one at a time as classic single transfers (CTI=000).
- Acks, read data and errors return upstream in request order.
- Sits between pipelined bus masters and legacy classic-only peripherals.

---
 rtl/wbp2classic.sv | 238 +++++++++++++++++++++++
 tb/tb_wbp2classic.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbp2classic.sv
// wbp2classic: Wishbone pipelined slave port -> Wishbone classic master port.
//
// Pipelined requests are queued in a small FIFO and replayed downstream one
// at a time as classic single transfers (CTI=000). The head entry stays in
// the FIFO while its downstream transfer is outstanding. It is popped on
// the downstream ack, and if another entry is queued behind it, that entry
// is loaded at the same edge. Responses therefore return upstream in
// request order.
//
// Ports
//   i_clk, i_reset_n         clock, asynchronous active-low reset
//   i_scyc .. i_ssel         upstream pipelined request
//   o_sstall                 upstream stall (from registered state and i_scyc)
//   o_sack, o_sdata, o_serr  upstream response, one cycle per request
//   o_mcyc .. o_msel         downstream classic request, all registered
//   o_mcti, o_mbte           constant classic-cycle tags
//   i_mack, i_mdata, i_merr  downstream response
//
// States
//   IDLE | no downstream transfer; issue the FIFO head if one is present
//   BUSY | downstream transfer outstanding; outputs held until ack or err
//   ERR  | downstream error seen; stall upstream until i_scyc drops

module wbp2classic #(
  parameter int AW     = 12,
  parameter int DW     = 32,
  parameter int LGFIFO = 2
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  // upstream (pipelined)
  input  logic              i_scyc,
  input  logic              i_sstb,
  input  logic              i_swe,
  input  logic [AW-1:0]     i_saddr,
  input  logic [DW-1:0]     i_sdata,
  input  logic [DW/8-1:0]   i_ssel,
  output logic              o_sstall,
  output logic              o_sack,
  output logic [DW-1:0]     o_sdata,
  output logic              o_serr,
  // downstream (classic)
  output logic              o_mcyc,
  output logic              o_mstb,
  output logic              o_mwe,
  output logic [AW-1:0]     o_maddr,
  output logic [DW-1:0]     o_mdata,
  output logic [DW/8-1:0]   o_msel,
  output logic [2:0]        o_mcti,
  output logic [1:0]        o_mbte,
  input  logic              i_mack,
  input  logic [DW-1:0]     i_mdata,
  input  logic              i_merr
);

  localparam int SW    = DW / 8;
  localparam int PW    = LGFIFO + 1;
  localparam int DEPTH = 1 << LGFIFO;
  localparam int EW    = 1 + AW + DW + SW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // request FIFO
  logic [EW-1:0]     mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, wr_ptr_nxt, count;
  logic [LGFIFO-1:0] rd_idx, nxt_idx;
  logic              empty, full, push;
  logic [EW-1:0]     head_ent, next_ent, load_ent;

  // decoded per-edge actions
  logic load_head, load_next, pop, flush, ack_evt, err_evt;

  assign o_mcti = 3'b000;
  assign o_mbte = 2'b00;

  // Pointers carry one extra bit so full (MSBs differ) and empty (equal)
  // are distinguishable; the difference is the occupancy.
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (count == PW'(DEPTH));

  // Never a function of i_sstb, so a master may use it to decide on stb.
  assign o_sstall = full || (state == ERR) || !i_scyc;
  assign push     = i_scyc && i_sstb && !o_sstall;

  assign wr_ptr_nxt = wr_ptr + PW'(push);
  assign rd_idx     = rd_ptr[LGFIFO-1:0];
  assign nxt_idx    = rd_idx + LGFIFO'(1);
  assign head_ent   = mem[rd_idx];
  assign next_ent   = mem[nxt_idx];
  assign load_ent   = load_head ? head_ent : next_ent;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (!i_scyc) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) state_nxt = BUSY;
        end
        BUSY: begin
          if (i_merr) begin
            state_nxt = ERR;
          end else if (i_mack && (count == PW'(1))) begin
            // the entry being acked is the last one held
            state_nxt = IDLE;
          end
        end
        ERR:     state_nxt = ERR;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FSM: action decode
  // ---------------------------------------------------------------------
  always_comb begin
    load_head = 1'b0;
    load_next = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
    ack_evt   = 1'b0;
    err_evt   = 1'b0;
    if (!i_scyc) begin
      // upstream abandoned the cycle: drop everything, answer nothing
      flush = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          load_head = !empty;
        end
        BUSY: begin
          if (i_merr) begin
            // error wins over a simultaneous ack
            err_evt = 1'b1;
            flush   = 1'b1;
          end else if (i_mack) begin
            ack_evt   = 1'b1;
            pop       = 1'b1;
            load_next = (count > PW'(1));
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FIFO pointers and storage
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      // A flush also discards a request accepted on the same edge, so
      // nothing queued behind an error is ever issued.
      if (flush) begin
        rd_ptr <= wr_ptr_nxt;
      end else if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr[LGFIFO-1:0]] <= {i_swe, i_saddr, i_sdata, i_ssel};
    end
  end

  // ---------------------------------------------------------------------
  // Registered downstream request and upstream response
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_mcyc  <= 1'b0;
      o_mstb  <= 1'b0;
      o_mwe   <= 1'b0;
      o_maddr <= '0;
      o_mdata <= '0;
      o_msel  <= '0;
      o_sack  <= 1'b0;
      o_serr  <= 1'b0;
      o_sdata <= '0;
    end else begin
      o_sack <= ack_evt;
      o_serr <= err_evt;
      if (ack_evt) begin
        o_sdata <= i_mdata;
      end
      if (load_head || load_next) begin
        o_mcyc <= 1'b1;
        o_mstb <= 1'b1;
        {o_mwe, o_maddr, o_mdata, o_msel} <= load_ent;
      end else if (flush || pop) begin
        o_mcyc <= 1'b0;
        o_mstb <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------
  a_one_response : assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !(o_sack && o_serr));

  a_count_bound : assert property (@(posedge i_clk) disable iff (!i_reset_n)
    count <= PW'(DEPTH));

  a_cyc_stb : assert property (@(posedge i_clk) disable iff (!i_reset_n)
    o_mcyc == o_mstb);

endmodule

// File: tb/tb_wbp2classic.sv
module tb_wbp2classic;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 4;

  logic clk, rst_n;
  logic i_scyc, i_sstb, i_swe;
  logic [AW-1:0] i_saddr;
  logic [DW-1:0] i_sdata;
  logic [SW-1:0] i_ssel;
  logic o_sstall, o_sack, o_serr;
  logic [DW-1:0] o_sdata;
  logic o_mcyc, o_mstb, o_mwe;
  logic [AW-1:0] o_maddr;
  logic [DW-1:0] o_mdata;
  logic [SW-1:0] o_msel;
  logic [2:0] o_mcti;
  logic [1:0] o_mbte;
  logic i_mack, i_merr;
  logic [DW-1:0] i_mdata;

  logic auto_ack, mack_man;
  assign i_mack = auto_ack ? o_mstb : mack_man;

  wbp2classic #(.AW(AW), .DW(DW), .LGFIFO(2)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_scyc(i_scyc), .i_sstb(i_sstb), .i_swe(i_swe), .i_saddr(i_saddr),
    .i_sdata(i_sdata), .i_ssel(i_ssel),
    .o_sstall(o_sstall), .o_sack(o_sack), .o_sdata(o_sdata), .o_serr(o_serr),
    .o_mcyc(o_mcyc), .o_mstb(o_mstb), .o_mwe(o_mwe), .o_maddr(o_maddr),
    .o_mdata(o_mdata), .o_msel(o_msel), .o_mcti(o_mcti), .o_mbte(o_mbte),
    .i_mack(i_mack), .i_mdata(i_mdata), .i_merr(i_merr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Transaction-level model: a queue of accepted requests; while a
  // transfer is active the queue head is what is on the downstream bus.
  // ------------------------------------------------------------------
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] sel;
  } req_t;

  req_t q[$];
  bit m_active, m_err, e_sack, e_serr;
  logic [DW-1:0] e_sdata;
  bit acc;
  req_t r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_active = 0; m_err = 0; e_sack = 0; e_serr = 0; e_sdata = '0;
    end else begin
      e_sack = 0;
      e_serr = 0;
      acc = i_scyc && i_sstb && !m_err && (q.size() < DEPTH);
      r = '{i_swe, i_saddr, i_sdata, i_ssel};
      if (!i_scyc) begin
        q.delete();
        m_active = 0;
        m_err = 0;
      end else if (m_err) begin
        acc = 0;
      end else if (m_active && i_merr) begin
        q.delete();
        m_active = 0;
        m_err = 1;
        e_serr = 1;
      end else begin
        if (m_active && i_mack) begin
          e_sack = 1;
          e_sdata = i_mdata;
          void'(q.pop_front());
          m_active = (q.size() > 0);
        end else if (!m_active && q.size() > 0) begin
          m_active = 1;
        end
        if (acc) q.push_back(r);
      end
    end
  end

  // ------------------------------------------------------------------
  // Per-cycle compare and observation counters
  // ------------------------------------------------------------------
  int cyc = 0, mstb_hi = 0, sack_seen = 0;
  bit rec_on = 0, saw_r2 = 0;
  logic [AW-1:0] ack_addr[$];
  int ack_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (o_mstb) mstb_hi++;
    if (o_sack) sack_seen++;
    if (rec_on && o_mstb && i_mack) begin
      ack_addr.push_back(o_maddr);
      ack_cyc.push_back(cyc);
    end
    if (o_mstb && o_maddr == 12'h028) saw_r2 = 1;
    check("cyc_mcyc", o_mcyc, m_active);
    check("cyc_mstb", o_mstb, m_active);
    check("cyc_sstall", o_sstall, (q.size() == DEPTH) || m_err || !i_scyc);
    check("cyc_sack", o_sack, e_sack);
    check("cyc_serr", o_serr, e_serr);
    check("cyc_mcti", o_mcti, 3'b000);
    check("cyc_mbte", o_mbte, 2'b00);
    if (m_active && q.size() > 0) begin
      check("cyc_maddr", o_maddr, q[0].addr);
      check("cyc_mwe", o_mwe, q[0].we);
      check("cyc_mdata", o_mdata, q[0].data);
      check("cyc_msel", o_msel, q[0].sel);
    end
    if (e_sack) check("cyc_sdata", o_sdata, e_sdata);
  end

  // ------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [SW-1:0] s);
    bit done;
    int n;
    i_scyc = 1; i_sstb = 1; i_swe = we; i_saddr = a; i_sdata = d; i_ssel = s;
    done = 0;
    n = 0;
    while (!done && n < 50) begin
      done = !o_sstall;
      tick();
      n++;
    end
    i_sstb = 0;
    check("push_accepted", done, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mcyc"}, o_mcyc, 0);
    check({tag, "_mstb"}, o_mstb, 0);
    check({tag, "_mwe"}, o_mwe, 0);
    check({tag, "_maddr"}, o_maddr, 0);
    check({tag, "_mdata"}, o_mdata, 0);
    check({tag, "_msel"}, o_msel, 0);
    check({tag, "_sack"}, o_sack, 0);
    check({tag, "_serr"}, o_serr, 0);
    check({tag, "_sdata"}, o_sdata, 0);
  endtask

  int base_hi, base_sack, n;

  initial begin
    rst_n = 0; auto_ack = 0; mack_man = 0; i_merr = 0; i_mdata = '0;
    i_scyc = 1; i_sstb = 0; i_swe = 0; i_saddr = '0; i_sdata = '0; i_ssel = '0;
    #12;
    check_all_zero("reset");
    tick();
    rst_n = 1;
    tick();

    // 1: single read, slave acks two cycles after stb rises
    base_hi = mstb_hi;
    push(0, 12'h010, 32'h0, 4'hF);
    tick();
    check("t1_mstb_up", o_mstb, 1);
    check("t1_maddr", o_maddr, 12'h010);
    tick();
    tick();
    mack_man = 1; i_mdata = 32'hDEADBEEF;
    tick();
    mack_man = 0;
    check("t1_sack", o_sack, 1);
    check("t1_sdata", o_sdata, 32'hDEADBEEF);
    check("t1_mcyc_down", o_mcyc, 0);
    check("t1_mstb_cycles", mstb_hi - base_hi, 3);
    tick();
    check("t1_sack_single", o_sack, 0);

    // 2: fill four entries with no ack, then a zero-wait slave drains five
    base_sack = sack_seen;
    for (int i = 0; i < 4; i++) push(1, 12'h100 + AW'(i), 32'hA0 + i, 4'hF);
    check("t2_stall_full", o_sstall, 1);
    rec_on = 1;
    auto_ack = 1;
    push(1, 12'h104, 32'hA4, 4'h3);
    n = 0;
    while (o_mstb && n < 50) begin tick(); n++; end
    check("t2_drain_bound", n < 50, 1);
    auto_ack = 0;
    rec_on = 0;
    tick();
    check("t2_sack_count", sack_seen - base_sack, 5);
    check("t2_ack_count", ack_addr.size(), 5);
    for (int i = 0; i < 5 && i < ack_addr.size(); i++)
      check("t2_ack_addr", ack_addr[i], 12'h100 + AW'(i));
    if (ack_cyc.size() == 5) check("t2_back_to_back", ack_cyc[4] - ack_cyc[0], 4);

    // 3: three queued reads, error on the second
    push(0, 12'h020, 0, 4'hF);
    push(0, 12'h024, 0, 4'hF);
    push(0, 12'h028, 0, 4'hF);
    mack_man = 1; i_mdata = 32'h11111111;
    tick();
    mack_man = 0;
    check("t3_sack", o_sack, 1);
    check("t3_sdata", o_sdata, 32'h11111111);
    check("t3_maddr_second", o_maddr, 12'h024);
    i_merr = 1;
    tick();
    i_merr = 0;
    check("t3_serr", o_serr, 1);
    check("t3_no_sack", o_sack, 0);
    check("t3_mstb_down", o_mstb, 0);
    check("t3_stall_err", o_sstall, 1);
    tick();
    tick();
    check("t3_stall_held", o_sstall, 1);
    check("t3_serr_once", o_serr, 0);
    i_scyc = 0;
    tick();
    i_scyc = 1;
    #1;
    check("t3_stall_released", o_sstall, 0);
    check("t3_third_never_issued", saw_r2, 0);
    tick();

    // 4: upstream abort while the first of two is outstanding
    base_sack = sack_seen;
    push(1, 12'h030, 32'h30, 4'hF);
    push(0, 12'h034, 0, 4'hF);
    check("t4_busy", o_mstb, 1);
    i_scyc = 0;
    tick();
    check("t4_mcyc_abort", o_mcyc, 0);
    check("t4_mstb_abort", o_mstb, 0);
    i_scyc = 1; mack_man = 1;
    tick();
    mack_man = 0;
    check("t4_late_ack_ignored", o_sack, 0);
    tick();
    check("t4_fifo_empty", o_mstb, 0);
    check("t4_no_response", sack_seen - base_sack, 0);

    // 5: asynchronous reset mid-transfer, then a normal write
    push(1, 12'h040, 32'h40, 4'hF);
    tick();
    check("t5_busy", o_mstb, 1);
    #2;
    rst_n = 0;
    #1;
    check_all_zero("t5_async");
    #4;
    rst_n = 1;
    tick();
    push(1, 12'h044, 32'hCAFEF00D, 4'hC);
    tick();
    check("t5_mstb", o_mstb, 1);
    check("t5_maddr", o_maddr, 12'h044);
    check("t5_mwe", o_mwe, 1);
    check("t5_mdata", o_mdata, 32'hCAFEF00D);
    check("t5_msel", o_msel, 4'hC);
    mack_man = 1; i_mdata = 32'h5A5A5A5A;
    tick();
    mack_man = 0;
    check("t5_sack", o_sack, 1);
    check("t5_sdata", o_sdata, 32'h5A5A5A5A);
    tick();

    // 6: ack and error together, error wins
    push(0, 12'h050, 0, 4'hF);
    tick();
    mack_man = 1; i_merr = 1;
    tick();
    mack_man = 0; i_merr = 0;
    check("t6_serr", o_serr, 1);
    check("t6_sack", o_sack, 0);
    check("t6_stall_err", o_sstall, 1);
    check("t6_mstb", o_mstb, 0);
    i_scyc = 0;
    tick();
    i_scyc = 1;
    tick();
    check("t6_recovered", o_sstall, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
